grid_argmax_stream: RTL
=======================

Name: grid_argmax_stream

Overview:
- Streaming successor to the fixed 8x8 combinational max finder used by the paint-layer stage.
- Accepts one GRID_W x GRID_H region of per-pixel error values, one value per accepted beat, in raster order.
- Produces the argmax coordinate, the max value, the region error sum and a stroke-decision flag.
- Sits between the error-image reader and the stroke generator. Each output is returned through a valid/ready handshake.

Parameters:
- DATA_W, 24, width of each error sample and of the threshold.
- GRID_W, 8, region width in samples (>=2).
- GRID_H, 8, region height in samples (>=1).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  begin a region; honoured only in IDLE, or in DONE while i_ready=1
- i_abort  in  1  synchronous discard of the current region
- i_threshold  in  DATA_W  mean-error threshold; latched when start is accepted
- i_valid  in  1  input sample valid
- o_ready  out  1  block can accept a sample
- i_data  in  DATA_W  error sample
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result
- o_max_x  out  XW=max(1,$clog2(GRID_W))  column of the max
- o_max_y  out  YW=max(1,$clog2(GRID_H))  row of the max
- o_max_val  out  DATA_W  max value
- o_sum  out  SUM_W=DATA_W+$clog2(GRID_W*GRID_H)  sum of all samples
- o_stroke  out  1  o_sum > i_threshold*GRID_W*GRID_H
- o_busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - state goes to IDLE.
  - All outputs and internal registers are 0 (o_ready=0, o_valid=0).
  - Reset during ACCUM or DONE drops the region silently.
- State IDLE:
  - o_ready=0.
  - i_start=1 latches the threshold, clears sum, max and beat counter, and moves to ACCUM.
- State ACCUM:
  - o_ready=1. A beat is accepted when i_valid && o_ready.
  - Beat k (0-based) maps to x=k mod GRID_W, y=k div GRID_W.
  - Beat 0 loads max_val, max_x and max_y unconditionally.
  - A later beat updates the max only if i_data > max_val (strict). Ties keep the first occurrence in raster order.
  - sum += i_data on every accepted beat. SUM_W is sized so the sum never overflows.
  - Column and row counters: column wraps at GRID_W-1, and the row increments on that wrap.
  - Accepting beat GRID_W*GRID_H-1 moves to DONE.
- State DONE:
  - o_valid=1 on the cycle after the last beat is accepted (latency 1).
  - All result outputs are held stable while o_valid && !i_ready.
  - o_stroke is registered on the DONE transition. It uses the final sum compared against threshold*AREA, computed at SUM_W width with a constant multiply.
  - i_ready=1 with i_start=0: go to IDLE; o_valid falls next cycle.
  - i_ready=1 with i_start=1: go directly to ACCUM (back-to-back regions). The new threshold is latched and o_valid falls.
- i_abort:
  - Any state goes to IDLE on the next cycle and the partial region is discarded.
  - Abort has priority over i_start and over a sample accepted in the same cycle.
  - In DONE, abort withdraws o_valid even without i_ready.
- Other boundary rules:
  - i_start in ACCUM is ignored.
  - i_start in DONE with i_ready=0 is ignored.
  - i_valid outside ACCUM is ignored because o_ready=0.
- Result registers are updated only on the ACCUM->DONE transition. Outputs therefore show the previous result until a new one is valid.

Decomposition:
- Package paint_pkg holds:
  - the DATA_W default constant,
  - the state enum {IDLE, ACCUM, DONE} as a 2-bit logic typedef,
  - a result struct typedef (max_x, max_y, max_val, sum, stroke) for the stroke-generator interface.
- No sub-module is needed. The running compare/accumulate datapath and the FSM form one module of roughly 150-200 lines.

Test Plan:
- Ramp: 8x8, threshold=31, data 0..63 with continuous valid -> max=63 at (7,7), sum=2016, stroke=1 (2016>1984). o_valid rises exactly one cycle after the 64th beat.
- Ties: 8x8, all samples 0x000100, threshold=0x100 -> max at (0,0), sum=16384, stroke=0 (equal is not greater).
- Single peak: 0x000010 everywhere except beat 19 = 0xFFFFFF -> max_x=3, max_y=2, max_val=0xFFFFFF, sum=0xFFFFFF+63*0x10.
- Handshake on the random ramp region: random i_valid gaps, i_ready held low 5 cycles in DONE -> outputs constant throughout. Then i_ready and i_start together -> next region is accepted with no IDLE cycle, and o_valid drops for that region.
- Abort: abort after 30 beats, then a full ramp region -> no o_valid for the aborted region; second result equals the ramp expectation. Abort asserted in DONE -> o_valid low next cycle.
- Reset and parameter check: reset asserted mid-ACCUM -> all outputs 0 immediately, o_busy=0. Rerun the ramp with GRID_W=4, GRID_H=2, data 0..7 -> max at (3,1), sum=28.

Source files
------------

// File: rtl/paint_pkg.sv
// Shared types for the paint-layer stroke path: FSM states, default sizing
// and the result record handed to the stroke generator.
package paint_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int GRID_W_DEF = 8;
    localparam int GRID_H_DEF = 8;

    localparam int RES_XW    = (GRID_W_DEF > 1) ? $clog2(GRID_W_DEF) : 1;
    localparam int RES_YW    = (GRID_H_DEF > 1) ? $clog2(GRID_H_DEF) : 1;
    localparam int RES_SUM_W = DATA_W_DEF + $clog2(GRID_W_DEF * GRID_H_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [RES_XW-1:0]     max_x;
        logic [RES_YW-1:0]     max_y;
        logic [DATA_W_DEF-1:0] max_val;
        logic [RES_SUM_W-1:0]  sum;
        logic                  stroke;
    } result_t;

endpackage

// File: rtl/grid_argmax_stream.sv
// Streaming argmax / sum over one GRID_W x GRID_H region of error samples,
// with a mean-error stroke decision, returned through a valid/ready handshake.
module grid_argmax_stream
    import paint_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    localparam int XW    = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    localparam int YW    = (GRID_H > 1) ? $clog2(GRID_H) : 1,
    localparam int SUM_W = DATA_W + $clog2(GRID_W * GRID_H)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_threshold,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XW-1:0]     o_max_x,
    output logic [YW-1:0]     o_max_y,
    output logic [DATA_W-1:0] o_max_val,
    output logic [SUM_W-1:0]  o_sum,
    output logic              o_stroke,
    output logic              o_busy
);

    localparam int              AREA      = GRID_W * GRID_H;
    localparam logic [XW-1:0]   COL_LAST  = XW'(GRID_W - 1);
    localparam logic [YW-1:0]   ROW_LAST  = YW'(GRID_H - 1);
    localparam logic [SUM_W-1:0] AREA_MUL = SUM_W'(AREA);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_threshold;
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_max_val;
    logic [XW-1:0]     r_max_x;
    logic [YW-1:0]     r_max_y;
    logic [XW-1:0]     r_col;
    logic [YW-1:0]     r_row;

    logic [XW-1:0]     r_res_x;
    logic [YW-1:0]     r_res_y;
    logic [DATA_W-1:0] r_res_val;
    logic [SUM_W-1:0]  r_res_sum;
    logic              r_res_stroke;

    logic              w_load;
    logic              w_accept;
    logic              w_last;
    logic              w_take;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [DATA_W-1:0] w_max_val_nxt;
    logic [XW-1:0]     w_max_x_nxt;
    logic [YW-1:0]     w_max_y_nxt;
    logic [SUM_W-1:0]  w_thr_area;

    // Abort outranks both a new start and a sample presented in the same cycle.
    assign w_load   = !i_abort && i_start &&
                      ((r_state == IDLE) || ((r_state == DONE) && i_ready));
    assign w_accept = !i_abort && i_valid && (r_state == ACCUM);
    assign w_last   = (r_col == COL_LAST) && (r_row == ROW_LAST);

    // First beat seeds the max; later beats replace it only when strictly larger.
    assign w_take        = ((r_col == '0) && (r_row == '0)) || (i_data > r_max_val);
    assign w_sum_nxt     = r_sum + SUM_W'(i_data);
    assign w_max_val_nxt = w_take ? i_data : r_max_val;
    assign w_max_x_nxt   = w_take ? r_col  : r_max_x;
    assign w_max_y_nxt   = w_take ? r_row  : r_max_y;
    assign w_thr_area    = SUM_W'(r_threshold) * AREA_MUL;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (i_valid && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_state_nxt = i_start ? ACCUM : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_threshold  <= '0;
            r_sum        <= '0;
            r_max_val    <= '0;
            r_max_x      <= '0;
            r_max_y      <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_res_x      <= '0;
            r_res_y      <= '0;
            r_res_val    <= '0;
            r_res_sum    <= '0;
            r_res_stroke <= 1'b0;
        end else if (w_load) begin
            r_threshold <= i_threshold;
            r_sum       <= '0;
            r_max_val   <= '0;
            r_max_x     <= '0;
            r_max_y     <= '0;
            r_col       <= '0;
            r_row       <= '0;
        end else if (w_accept) begin
            r_sum     <= w_sum_nxt;
            r_max_val <= w_max_val_nxt;
            r_max_x   <= w_max_x_nxt;
            r_max_y   <= w_max_y_nxt;
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + YW'(1);
            end else begin
                r_col <= r_col + XW'(1);
            end
            // Results move only on the closing beat, so the outputs keep the
            // previous region's values until the new ones are valid.
            if (w_last) begin
                r_res_x      <= w_max_x_nxt;
                r_res_y      <= w_max_y_nxt;
                r_res_val    <= w_max_val_nxt;
                r_res_sum    <= w_sum_nxt;
                r_res_stroke <= (w_sum_nxt > w_thr_area);
            end
        end
    end

    assign o_ready   = (r_state == ACCUM);
    assign o_valid   = (r_state == DONE);
    assign o_busy    = (r_state != IDLE);
    assign o_max_x   = r_res_x;
    assign o_max_y   = r_res_y;
    assign o_max_val = r_res_val;
    assign o_sum     = r_res_sum;
    assign o_stroke  = r_res_stroke;

endmodule
